// File: rtl/darkbus_arb.sv
// rtl/darkbus_arb.sv - two-master round-robin arbiter onto a single device bus
// Optional BUSY timeout with ERR response: define DARKBUS_ARB_TIMEOUT_EN.
module darkbus_arb #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        M0_EN,
    input  logic        M0_WE,
    input  logic        M0_RE,
    input  logic [3:0]  M0_BE,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic [31:0] M0_RDATA,
    output logic        M0_ACK,
    output logic        M0_ERR,
    input  logic        M1_EN,
    input  logic        M1_WE,
    input  logic        M1_RE,
    input  logic [3:0]  M1_BE,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic [31:0] M1_RDATA,
    output logic        M1_ACK,
    output logic        M1_ERR,
    output logic        S_EN,
    output logic        S_WE,
    output logic        S_RE,
    output logic [3:0]  S_BE,
    output logic [31:0] S_ADDR,
    output logic [31:0] S_WDATA,
    input  logic [31:0] S_RDATA,
    input  logic        S_WACK,
    input  logic        S_RACK
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic        gnt;
    logic        last;

    logic        req0;
    logic        req1;
    logic        pick1;
    logic        sel_we;
    logic        sel_re;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        dev_ack;
    logic [31:0] rd_val;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("darkbus_arb: TIMEOUT_CYC must be in 1..255");
    end

    // A strobe-less EN is not a request; on contention the master not granted last wins.
    assign req0  = M0_EN & (M0_WE | M0_RE);
    assign req1  = M1_EN & (M1_WE | M1_RE);
    assign pick1 = req1 & (~req0 | ~last);

    assign sel_we    = pick1 ? M1_WE    : M0_WE;
    assign sel_re    = pick1 ? M1_RE    : M0_RE;
    assign sel_be    = pick1 ? M1_BE    : M0_BE;
    assign sel_addr  = pick1 ? M1_ADDR  : M0_ADDR;
    assign sel_wdata = pick1 ? M1_WDATA : M0_WDATA;

    assign dev_ack = S_WACK | S_RACK;
    assign rd_val  = S_WE ? 32'h0 : S_RDATA;

`ifdef DARKBUS_ARB_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       tmo;
    assign tmo = (tcnt == 8'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last     <= 1'b1;
            M0_RDATA <= 32'h0;
            M0_ACK   <= 1'b0;
            M0_ERR   <= 1'b0;
            M1_RDATA <= 32'h0;
            M1_ACK   <= 1'b0;
            M1_ERR   <= 1'b0;
            S_EN     <= 1'b0;
            S_WE     <= 1'b0;
            S_RE     <= 1'b0;
            S_BE     <= 4'h0;
            S_ADDR   <= 32'h0;
            S_WDATA  <= 32'h0;
`ifdef DARKBUS_ARB_TIMEOUT_EN
            tcnt     <= 8'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt     <= pick1;
                        S_EN    <= 1'b1;
                        S_WE    <= sel_we;
                        S_RE    <= sel_re & ~sel_we;
                        S_BE    <= sel_be;
                        S_ADDR  <= sel_addr;
                        S_WDATA <= sel_wdata;
`ifdef DARKBUS_ARB_TIMEOUT_EN
                        tcnt    <= 8'h0;
`endif
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // Master EN is deliberately ignored here: a granted transfer always completes.
                    if (dev_ack) begin
                        S_EN     <= 1'b0;
                        S_WE     <= 1'b0;
                        S_RE     <= 1'b0;
                        M0_ACK   <= ~gnt;
                        M1_ACK   <= gnt;
                        M0_RDATA <= gnt ? 32'h0 : rd_val;
                        M1_RDATA <= gnt ? rd_val : 32'h0;
                        last     <= gnt;
                        state    <= RESP;
                    end
`ifdef DARKBUS_ARB_TIMEOUT_EN
                    else if (tmo) begin
                        S_EN    <= 1'b0;
                        S_WE    <= 1'b0;
                        S_RE    <= 1'b0;
                        S_BE    <= 4'h0;
                        S_ADDR  <= 32'h0;
                        S_WDATA <= 32'h0;
                        M0_ERR  <= ~gnt;
                        M1_ERR  <= gnt;
                        last    <= gnt;
                        state   <= RESP;
                    end else begin
                        tcnt <= tcnt + 8'h1;
                    end
`endif
                end
                RESP: begin
                    M0_ACK   <= 1'b0;
                    M1_ACK   <= 1'b0;
                    M0_ERR   <= 1'b0;
                    M1_ERR   <= 1'b0;
                    M0_RDATA <= 32'h0;
                    M1_RDATA <= 32'h0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_darkbus_arb.sv
// tb/tb_darkbus_arb.sv - directed vector bench for darkbus_arb
// Timeout checks are compiled in when DARKBUS_ARB_TIMEOUT_EN is defined.
module tb_darkbus_arb;

`ifdef DARKBUS_ARB_TIMEOUT_EN
    localparam int unsigned TCYC = 4;
`else
    localparam int unsigned TCYC = 15;
`endif

    logic        xclk = 1'b0;
    logic        xres;
    logic        m0_en, m0_we, m0_re, m1_en, m1_we, m1_re;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_en, s_we, s_re;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata;
    logic        s_wack, s_rack;
    logic        dev_on;

    int checks = 0;
    int errors = 0;

    always #5 xclk = ~xclk;

    // Zero-wait device model, gated by dev_on so tests can stall it.
    assign s_wack = dev_on & s_en & s_we;
    assign s_rack = dev_on & s_en & s_re;

    darkbus_arb #(.TIMEOUT_CYC(TCYC)) dut (
        .XCLK(xclk), .XRES(xres),
        .M0_EN(m0_en), .M0_WE(m0_we), .M0_RE(m0_re), .M0_BE(m0_be),
        .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata), .M0_RDATA(m0_rdata),
        .M0_ACK(m0_ack), .M0_ERR(m0_err),
        .M1_EN(m1_en), .M1_WE(m1_we), .M1_RE(m1_re), .M1_BE(m1_be),
        .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata), .M1_RDATA(m1_rdata),
        .M1_ACK(m1_ack), .M1_ERR(m1_err),
        .S_EN(s_en), .S_WE(s_we), .S_RE(s_re), .S_BE(s_be),
        .S_ADDR(s_addr), .S_WDATA(s_wdata),
        .S_RDATA(s_rdata), .S_WACK(s_wack), .S_RACK(s_rack)
    );

    typedef struct {
        logic [2:0]  c0;
        logic [3:0]  be0;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [2:0]  c1;
        logic [3:0]  be1;
        logic [31:0] a1;
        logic [31:0] w1;
        logic [31:0] dev;
        int          gnt;
        logic        ewe;
        logic        ere;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] c0, input logic [3:0] be0, input logic [31:0] a0,
                         input logic [31:0] w0, input logic [2:0] c1, input logic [3:0] be1,
                         input logic [31:0] a1, input logic [31:0] w1);
        {m0_en, m0_we, m0_re} = c0;
        m0_be = be0; m0_addr = a0; m0_wdata = w0;
        {m1_en, m1_we, m1_re} = c1;
        m1_be = be1; m1_addr = a1; m1_wdata = w1;
    endtask

    task automatic release_all();
        drive(3'b000, 4'h0, 32'h0, 32'h0, 3'b000, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".m0_ack"}, {31'h0, m0_ack}, 32'h0);
        chk({tag, ".m1_ack"}, {31'h0, m1_ack}, 32'h0);
        chk({tag, ".m0_err"}, {31'h0, m0_err}, 32'h0);
        chk({tag, ".m1_err"}, {31'h0, m1_err}, 32'h0);
        chk({tag, ".m0_rdata"}, m0_rdata, 32'h0);
        chk({tag, ".m1_rdata"}, m1_rdata, 32'h0);
    endtask

    initial begin
        logic any_err;
        // Round-robin expectation after reset: M0, M1, M0, M1 under repeated contention.
        vecs[0] = '{3'b101, 4'h0, 32'h100, 32'h0, 3'b101, 4'h0, 32'h200, 32'h0, 32'h11111111, 0, 1'b0, 1'b1, 32'h11111111};
        vecs[1] = '{3'b101, 4'h0, 32'h100, 32'h0, 3'b101, 4'h0, 32'h200, 32'h0, 32'h22222222, 1, 1'b0, 1'b1, 32'h22222222};
        vecs[2] = '{3'b101, 4'h0, 32'h100, 32'h0, 3'b101, 4'h0, 32'h200, 32'h0, 32'h33333333, 0, 1'b0, 1'b1, 32'h33333333};
        vecs[3] = '{3'b101, 4'h0, 32'h100, 32'h0, 3'b101, 4'h0, 32'h200, 32'h0, 32'h44444444, 1, 1'b0, 1'b1, 32'h44444444};
        vecs[4] = '{3'b101, 4'h0, 32'h10, 32'h0, 3'b000, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[5] = '{3'b000, 4'h0, 32'h0, 32'h0, 3'b110, 4'b0010, 32'h8, 32'h0000AB00, 32'hDEADBEEF, 1, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{3'b100, 4'hF, 32'h50, 32'h1, 3'b000, 4'h0, 32'h0, 32'h0, 32'h0, 2, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{3'b111, 4'h0, 32'h20, 32'h12345678, 3'b000, 4'h0, 32'h0, 32'h0, 32'h55, 0, 1'b1, 1'b0, 32'h0};
        vecs[8] = '{3'b100, 4'h0, 32'h60, 32'h0, 3'b101, 4'h0, 32'h44, 32'h0, 32'hA5A5A5A5, 1, 1'b0, 1'b1, 32'hA5A5A5A5};
        vecs[9] = '{3'b101, 4'h3, 32'h30, 32'h0, 3'b000, 4'h0, 32'h0, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b1, 32'h0BADF00D};

        xres = 1'b1; dev_on = 1'b0; s_rdata = 32'h0;
        release_all();
        repeat (2) @(posedge xclk);
        @(negedge xclk);
        chk_quiet("reset");
        chk("reset.s_en", {29'h0, s_en, s_we, s_re}, 32'h0);
        chk("reset.s_cmd", s_addr | s_wdata | {28'h0, s_be}, 32'h0);
        xres = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge xclk);
            drive(vecs[i].c0, vecs[i].be0, vecs[i].a0, vecs[i].w0,
                  vecs[i].c1, vecs[i].be1, vecs[i].a1, vecs[i].w1);
            s_rdata = vecs[i].dev;
            dev_on  = 1'b1;
            if (vecs[i].gnt == 2) begin
                repeat (2) begin
                    @(negedge xclk);
                    chk($sformatf("v%0d.s_en", i), {31'h0, s_en}, 32'h0);
                    chk_quiet($sformatf("v%0d", i));
                end
            end else begin
                @(negedge xclk);
                chk($sformatf("v%0d.s_en", i), {31'h0, s_en}, 32'h1);
                chk($sformatf("v%0d.s_we", i), {31'h0, s_we}, {31'h0, vecs[i].ewe});
                chk($sformatf("v%0d.s_re", i), {31'h0, s_re}, {31'h0, vecs[i].ere});
                chk($sformatf("v%0d.s_be", i), {28'h0, s_be}, {28'h0, vecs[i].gnt == 1 ? vecs[i].be1 : vecs[i].be0});
                chk($sformatf("v%0d.s_addr", i), s_addr, vecs[i].gnt == 1 ? vecs[i].a1 : vecs[i].a0);
                chk($sformatf("v%0d.s_wdata", i), s_wdata, vecs[i].gnt == 1 ? vecs[i].w1 : vecs[i].w0);
                chk($sformatf("v%0d.early_ack", i), {30'h0, m1_ack, m0_ack}, 32'h0);
                @(negedge xclk);
                chk($sformatf("v%0d.ack", i), {30'h0, m1_ack, m0_ack}, vecs[i].gnt == 1 ? 32'h2 : 32'h1);
                chk($sformatf("v%0d.err", i), {30'h0, m1_err, m0_err}, 32'h0);
                chk($sformatf("v%0d.m0_rdata", i), m0_rdata, vecs[i].gnt == 0 ? vecs[i].erd : 32'h0);
                chk($sformatf("v%0d.m1_rdata", i), m1_rdata, vecs[i].gnt == 1 ? vecs[i].erd : 32'h0);
                chk($sformatf("v%0d.s_en_off", i), {29'h0, s_en, s_we, s_re}, 32'h0);
            end
            release_all();
        end

        // Granted master drops EN during BUSY; transfer still completes.
        dev_on = 1'b0;
        @(negedge xclk);
        drive(3'b101, 4'h0, 32'h40, 32'h0, 3'b000, 4'h0, 32'h0, 32'h0);
        @(negedge xclk);
        chk("endrop.s_en1", {31'h0, s_en}, 32'h1);
        release_all();
        @(negedge xclk);
        chk("endrop.s_en2", {31'h0, s_en}, 32'h1);
        chk("endrop.noack", {30'h0, m1_ack, m0_ack}, 32'h0);
        s_rdata = 32'h600DCAFE; dev_on = 1'b1;
        @(negedge xclk);
        chk("endrop.ack", {30'h0, m1_ack, m0_ack}, 32'h1);
        chk("endrop.rdata", m0_rdata, 32'h600DCAFE);
        dev_on = 1'b0;

        // Reset while BUSY for M1; afterwards M0 must win contention although M0 was served last.
        @(negedge xclk);
        drive(3'b000, 4'h0, 32'h0, 32'h0, 3'b101, 4'h0, 32'h70, 32'h0);
        @(negedge xclk);
        chk("rst.busy_s_en", {31'h0, s_en}, 32'h1);
        xres = 1'b1;
        release_all();
        @(negedge xclk);
        chk("rst.s_en", {29'h0, s_en, s_we, s_re}, 32'h0);
        chk_quiet("rst");
        xres = 1'b0;
        @(negedge xclk);
        chk_quiet("rst.after");
        drive(3'b101, 4'h0, 32'h100, 32'h0, 3'b101, 4'h0, 32'h200, 32'h0);
        s_rdata = 32'h99; dev_on = 1'b1;
        @(negedge xclk);
        chk("rst.prio_addr", s_addr, 32'h100);
        @(negedge xclk);
        chk("rst.prio_ack", {30'h0, m1_ack, m0_ack}, 32'h1);
        chk("rst.prio_rdata", m0_rdata, 32'h99);
        release_all();
        dev_on = 1'b0;

`ifdef DARKBUS_ARB_TIMEOUT_EN
        // Device never acks: ERR after TCYC BUSY cycles.
        @(negedge xclk);
        drive(3'b101, 4'h0, 32'h80, 32'h0, 3'b000, 4'h0, 32'h0, 32'h0);
        s_rdata = 32'hFFFFFFFF;
        any_err = 1'b0;
        for (int c = 0; c < int'(TCYC); c++) begin
            @(negedge xclk);
            chk($sformatf("tmo.busy%0d", c), {31'h0, s_en}, 32'h1);
            any_err = any_err | m0_err | m1_err | m0_ack | m1_ack;
        end
        chk("tmo.no_early_resp", {31'h0, any_err}, 32'h0);
        @(negedge xclk);
        chk("tmo.err", {30'h0, m1_err, m0_err}, 32'h1);
        chk("tmo.ack", {30'h0, m1_ack, m0_ack}, 32'h0);
        chk("tmo.rdata", m0_rdata, 32'h0);
        chk("tmo.s_en", {29'h0, s_en, s_we, s_re}, 32'h0);
        release_all();
        // Ack arriving in the final BUSY cycle wins over the timeout.
        @(negedge xclk);
        drive(3'b101, 4'h0, 32'h84, 32'h0, 3'b000, 4'h0, 32'h0, 32'h0);
        for (int c = 0; c < int'(TCYC); c++) @(negedge xclk);
        s_rdata = 32'h77; dev_on = 1'b1;
        @(negedge xclk);
        chk("tmo.prec_ack", {30'h0, m1_ack, m0_ack}, 32'h1);
        chk("tmo.prec_err", {30'h0, m1_err, m0_err}, 32'h0);
        chk("tmo.prec_rdata", m0_rdata, 32'h77);
        release_all();
        dev_on = 1'b0;
`else
        // Without timeout, BUSY waits indefinitely and ERR never fires.
        @(negedge xclk);
        drive(3'b000, 4'h0, 32'h0, 32'h0, 3'b101, 4'h0, 32'h90, 32'h0);
        any_err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge xclk);
            any_err = any_err | m0_err | m1_err | m0_ack | m1_ack | ~s_en;
        end
        chk("wait.no_err", {31'h0, any_err}, 32'h0);
        s_rdata = 32'h1234ABCD; dev_on = 1'b1;
        @(negedge xclk);
        chk("wait.ack", {30'h0, m1_ack, m0_ack}, 32'h2);
        chk("wait.rdata", m1_rdata, 32'h1234ABCD);
        release_all();
        dev_on = 1'b0;
`endif
        repeat (2) @(negedge xclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
